vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator for the 640x480@60 VGA output path. Walks pixel and
//  line counters, producing col/row/valid for pattern_gen (directly downstream)
//  plus hsync/vsync for the connector and one-clock frame/line start strobes for
//  game-logic updates. Advances only on pix_en, so it runs from a fast system clock.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  SYNC_POL  0    asserted level of hsync/vsync (0 = active-low)
// PORTS
//  clk          in   1   system clock; the single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  pix_en       in   1   pixel-tick enable; counters advance only when high
//  col          out  10  current horizontal position, 0..H_TOTAL-1
//  row          out  10  current vertical position, 0..V_TOTAL-1
//  valid        out  1   high iff col<H_ACTIVE and row<V_ACTIVE
//  hsync        out  1   horizontal sync, polarity per SYNC_POL
//  vsync        out  1   vertical sync, polarity per SYNC_POL
//  line_start   out  1   1-clk pulse when col wraps to 0
//  frame_start  out  1   1-clk pulse when (col,row) wraps to (0,0)
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL likewise (525).
//    Both must be <= 1024; elaboration-time assertion otherwise.
//  - Reset (async assert, sync release): hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1,
//    so col = 799, row = 524, valid = 0, hsync = vsync = !SYNC_POL, and
//    line_start = frame_start = 0. The first pix_en tick then lands on (0,0).
//  - On clk with pix_en = 1:
//    - hcnt increments and wraps from H_TOTAL-1 to 0.
//    - On that wrap, vcnt increments and wraps from V_TOTAL-1 to 0.
//  - With pix_en = 0, all counters and level outputs hold.
//  - All outputs are registered, decoded from next-state counter values. There are
//    no combinational paths from inputs to outputs, and no glitches on sync lines.
//  - Latency: col/row/valid/sync change on the same clk edge that the pix_en tick
//    occurs, i.e. 1 clk after pix_en is sampled high.
//  - hsync is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
//    (656..751). vsync is asserted for lines 490..491 and spans whole lines,
//    independent of hcnt.
//  - line_start is high for exactly one clk after a tick that set hcnt to 0.
//    frame_start is the same, but only when vcnt is also 0; it coincides with a
//    line_start. Both pulses are 1 clk wide regardless of how long pix_en stays high.
//  - Registered col/row/valid and rgb all remain pixel-aligned.
//  - Reset mid-frame: outputs return to reset values immediately (async), and
//    scanning restarts from the reset position. No partial-pulse state survives.
//  - pix_en held high continuously: one line = 800 clks; one frame = 420000 clks.
// STRUCTURE
//  - vga_pkg holds the default timing constants (640x480 set), the rgb6_t typedef,
//    and the named 6-bit colour constants shared with pattern_gen.
//  - Sub-module mod_counter #(WIDTH, MODULUS): an enabled wrap counter with
//    wrap-pulse output and a reset value of MODULUS-1. There are two instances;
//    the vertical instance is enabled by the horizontal wrap gated with pix_en.
//  - Top level holds the sync/valid/strobe decode and the output registers.
// TESTING
//  1. Hold rst_n=0 -> col=799, row=524, valid=0, hsync=vsync=1, both strobes 0.
//  2. Release reset, then first pix_en tick -> col=0, row=0, valid=1, and
//     frame_start=line_start=1 for 1 clk.
//  3. pix_en held high, one line -> valid high for cols 0..639 only, col=640 gives
//     valid=0, hsync low for exactly 96 clks starting at col 656, line_start
//     every 800 clks.
//  4. Full frame -> vsync low for rows 490..491 (1600 clks), row 480 gives
//     valid=0, frame_start exactly once per 420000 clks, row wraps 524 -> 0.
//  5. pix_en=1 on every 2nd clk -> counters advance at half rate, col/row hold
//     between ticks, strobes still exactly 1 clk wide, line period 1600 clks.
//  6. Assert rst_n at col=300, row=200 -> outputs go to reset values without a
//     clk edge; release -> next tick gives (0,0) with frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 raster timing, the 6-bit colour type
// and the named palette used by the timing generator and pattern_gen.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic SYNC_POL_DEF = 1'b0;

  // Counter width shared by col/row; totals must fit below 2**CNT_W.
  localparam int CNT_W = 10;

  // 2 bits per channel, {r,g,b}.
  typedef logic [5:0] rgb6_t;

  localparam rgb6_t C_BLACK   = 6'b00_00_00;
  localparam rgb6_t C_WHITE   = 6'b11_11_11;
  localparam rgb6_t C_RED     = 6'b11_00_00;
  localparam rgb6_t C_GREEN   = 6'b00_11_00;
  localparam rgb6_t C_BLUE    = 6'b00_00_11;
  localparam rgb6_t C_YELLOW  = 6'b11_11_00;
  localparam rgb6_t C_CYAN    = 6'b00_11_11;
  localparam rgb6_t C_MAGENTA = 6'b11_00_11;
  localparam rgb6_t C_GREY    = 6'b01_01_01;

  // Drive level of a sync line given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Enabled modulo counter. Resets to MODULUS-1 so the first enabled tick lands
// on 0; exposes the next-state value so the parent can register decodes of it.
module mod_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = en && (cnt_q == LAST);
    if (en) begin
      cnt_d = wrap_d ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;
  assign wrap     = wrap_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters advanced by pix_en, with
// registered col/row/valid, sync lines and one-clock line/frame start strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt, hcnt_d;
  logic [CNT_W-1:0] vcnt, vcnt_d;
  logic             h_wrap, v_wrap, v_en;

  logic valid_q, valid_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (H_TOTAL)
  ) u_hcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (pix_en),
    .cnt      (hcnt),
    .cnt_next (hcnt_d),
    .wrap     (h_wrap)
  );

  assign v_en = h_wrap & pix_en;

  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (V_TOTAL)
  ) u_vcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (v_en),
    .cnt      (vcnt),
    .cnt_next (vcnt_d),
    .wrap     (v_wrap)
  );

  // Decode from next-state counts so every output flop updates on the tick edge.
  always_comb begin
    valid_d       = (hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C);
    hsync_d       = sync_level((hcnt_d >= HS_START) && (hcnt_d < HS_END), SYNC_POL);
    vsync_d       = sync_level((vcnt_d >= VS_START) && (vcnt_d < VS_END), SYNC_POL);
    line_start_d  = h_wrap;
    frame_start_d = h_wrap & v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign col         = hcnt;
  assign row         = vcnt;
  assign valid       = valid_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
